// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - N-channel registered mux with round-robin or fixed-select arbitration
module rr_mux_arbiter #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      sel_mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_chan_q, out_chan_d;
  logic                out_valid_q, out_valid_d;

  logic                load;
  logic                grant_valid;
  logic [SEL_W-1:0]    grant;
  logic [WIDTH-1:0]    grant_data;
  logic [CHANNELS-1:0] vrot;
  int                  sum;

  assign load = !out_valid_q || out_ready;

  // Rotate valids so bit 0 is the channel at ptr; the first set bit is the winner.
  always_comb begin
    vrot        = CHANNELS'({in_valid, in_valid} >> ptr_q);
    grant_valid = 1'b0;
    grant       = '0;
    sum         = 0;
    if (!sel_mode) begin
      for (int j = 0; j < CHANNELS; j++) begin
        if (!grant_valid && vrot[j]) begin
          grant_valid = 1'b1;
          sum         = int'(ptr_q) + j;
          if (sum >= CHANNELS) sum = sum - CHANNELS;
          grant       = SEL_W'(sum);
        end
      end
    end else begin
      // An out-of-range sel matches no channel, so nothing is granted.
      for (int k = 0; k < CHANNELS; k++) begin
        if (sel == SEL_W'(k) && in_valid[k]) begin
          grant_valid = 1'b1;
          grant       = sel;
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant == SEL_W'(k)) begin
        grant_data  = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = rst_n && load && grant_valid;
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    if (load && grant_valid) begin
      out_data_d  = grant_data;
      out_chan_d  = grant;
      out_valid_d = 1'b1;
      if (!sel_mode) begin
        ptr_d = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed and randomized checks against a behavioural model
module tb_rr_mux_arbiter;

  localparam int W = 2;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic         sel_mode;
  logic [1:0]   sel;
  logic [W-1:0] out_data;
  logic [1:0]   out_chan;
  logic         out_valid;
  logic         out_ready;

  int errors = 0;
  int checks = 0;

  int m_ov = 0, m_od = 0, m_oc = 0, m_ptr = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel_mode(sel_mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: apply inputs, check handshake, clock, check registered outputs.
  task automatic step(input logic rst, input logic [N-1:0] v, input logic [N*W-1:0] d,
                      input logic m, input logic [1:0] s, input logic r);
    int g, exp_rdy;
    bit gv, ld;
    rst_n = rst; in_valid = v; in_data = d; sel_mode = m; sel = s; out_ready = r;
    #1;
    gv = 0; g = 0;
    if (!m) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (!gv && v[c]) begin gv = 1; g = c; end
      end
    end else if (int'(s) < N && v[s]) begin
      gv = 1; g = int'(s);
    end
    ld = (m_ov == 0) || r;
    exp_rdy = (rst && ld && gv) ? (1 << g) : 0;
    check("in_ready", int'(in_ready), exp_rdy);
    @(posedge clk);
    if (!rst) begin
      m_ov = 0; m_od = 0; m_oc = 0; m_ptr = 0;
    end else if (ld && gv) begin
      m_ov = 1; m_oc = g; m_od = int'((d >> (g * W)) & 8'h3);
      if (!m) m_ptr = (g + 1) % N;
    end else if (m_ov != 0 && r) begin
      m_ov = 0;
    end
    @(negedge clk);
    check("out_valid", int'(out_valid), m_ov);
    check("out_data", int'(out_data), m_od);
    check("out_chan", int'(out_chan), m_oc);
  endtask

  localparam logic [7:0] RAMP = {2'd3, 2'd2, 2'd1, 2'd0};

  initial begin
    rst_n = 0; in_valid = '1; in_data = RAMP; sel_mode = 0; sel = 0; out_ready = 1;

    step(0, 4'hF, RAMP, 0, 0, 1);
    step(0, 4'hF, RAMP, 0, 0, 1);
    check("reset_ready", int'(in_ready), 0);
    check("reset_valid", int'(out_valid), 0);

    for (int i = 0; i < 8; i++) begin
      step(1, 4'hF, RAMP, 0, 0, 1);
      check("rr_chan", int'(out_chan), i % N);
      check("rr_data", int'(out_data), i % N);
    end

    for (int i = 0; i < 4; i++) begin
      step(1, 4'b1010, RAMP, 0, 0, 1);
      check("sparse_chan", int'(out_chan), (i % 2 == 0) ? 1 : 3);
    end

    step(1, 4'b0100, RAMP, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'hF, RAMP, 0, 0, 0);
      check("stall_chan", int'(out_chan), 2);
      check("stall_data", int'(out_data), 2);
      check("stall_valid", int'(out_valid), 1);
    end
    step(1, 4'hF, RAMP, 0, 0, 1);
    check("unstall_chan", int'(out_chan), 3);

    for (int i = 0; i < 3; i++) begin
      step(1, 4'hF, RAMP, 1, 2, 1);
      check("fixed_chan", int'(out_chan), 2);
    end
    step(1, 4'b1011, RAMP, 1, 2, 1);
    check("fixed_drain", int'(out_valid), 0);
    step(1, 4'hF, RAMP, 0, 0, 1);
    check("resume_chan", int'(out_chan), 0);

    step(1, 4'b0010, RAMP, 0, 0, 1);
    step(1, 4'hF, RAMP, 0, 0, 0);
    step(0, 4'hF, RAMP, 0, 0, 0);
    check("rst_stall_valid", int'(out_valid), 0);
    step(1, 4'hF, RAMP, 0, 0, 1);
    check("rst_ptr_chan", int'(out_chan), 0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 40) != 0), 4'($urandom), 8'($urandom),
           ($urandom_range(0, 3) == 0), 2'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
